// File: rtl/cache_pkg.sv
// Shared cache-hierarchy constants and the memory responder state encoding.
package cache_pkg;

    localparam int OFFSET_BITS    = 6;
    localparam int INDEX_BITS     = 6;
    localparam int TAG_BITS       = 32 - INDEX_BITS - OFFSET_BITS;
    localparam int LINE_SIZE_BITS = (1 << OFFSET_BITS) * 8;
    localparam int BEATS          = LINE_SIZE_BITS / 32;
    localparam int BEAT_BITS      = $clog2(BEATS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RWAIT  = 3'd1,
        RBURST = 3'd2,
        WBURST = 3'd3,
        WWAIT  = 3'd4,
        WDONE  = 3'd5
    } state_t;

endpackage

// File: rtl/line_store_ram.sv
// Single-port word store: synchronous write, asynchronous read, no reset on contents.
module line_store_ram #(
    parameter int MEM_WORDS  = 4096,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = $clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Word write on the clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/cache_line_mem_responder.sv
// Main-memory model answering cache line fills and writebacks as 16-beat bursts
// with a programmable access latency.
module cache_line_mem_responder #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int LINE_SIZE_BYTES = 64,
    parameter int OFFSET_BITS     = 6,
    parameter int MEM_WORDS       = 4096,
    parameter int LATENCY         = 4
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             i_req_valid,
    output logic                                             o_req_ready,
    input  logic                                             i_req_write,
    input  logic [ADDRESS_WIDTH-OFFSET_BITS-1:0]             i_req_addr,
    input  logic [$clog2(LINE_SIZE_BYTES*8/DATA_WIDTH)-1:0]  i_req_word,
    input  logic                                             i_wdata_valid,
    output logic                                             o_wdata_ready,
    input  logic [DATA_WIDTH-1:0]                            i_wdata,
    output logic                                             o_rdata_valid,
    input  logic                                             i_rdata_ready,
    output logic [DATA_WIDTH-1:0]                            o_rdata,
    output logic                                             o_rdata_last,
    output logic                                             o_wr_done,
    output logic                                             o_busy
);

    import cache_pkg::*;

    localparam int LINE_BEATS     = LINE_SIZE_BYTES * 8 / DATA_WIDTH;
    localparam int PTR_BITS       = $clog2(LINE_BEATS);
    localparam int MEM_LINES      = MEM_WORDS / LINE_BEATS;
    localparam int SLOT_BITS      = $clog2(MEM_LINES);
    localparam int LINE_ADDR_BITS = ADDRESS_WIDTH - OFFSET_BITS;
    localparam logic [PTR_BITS-1:0] LAST_BEAT = PTR_BITS'(LINE_BEATS - 1);
    localparam logic [3:0] LAT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t                 state;
    state_t                 next_state;
    logic [3:0]             lat_cnt;
    logic [PTR_BITS-1:0]    beat_cnt;
    logic [PTR_BITS-1:0]    ptr;
    logic [SLOT_BITS-1:0]   slot;
    logic [SLOT_BITS-1:0]   slot_in;
    logic                   accept;
    logic                   ram_we;
    logic [DATA_WIDTH-1:0]  ram_q;
    logic                   req_ready;
    logic                   rdata_valid;
    logic                   wdata_ready;
    logic                   wr_done;
    logic                   busy;

    // Higher line addresses alias onto the available slots.
    assign slot_in = SLOT_BITS'(i_req_addr % LINE_ADDR_BITS'(MEM_LINES));
    assign accept  = i_req_valid && req_ready;
    assign ram_we  = wdata_ready && i_wdata_valid;

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (i_req_write) begin
                        next_state = WBURST;
                    end else if (LATENCY > 0) begin
                        next_state = RWAIT;
                    end else begin
                        next_state = RBURST;
                    end
                end else begin
                    next_state = IDLE;
                end
            end
            RWAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    next_state = RBURST;
                end else begin
                    next_state = RWAIT;
                end
            end
            RBURST: begin
                if (i_rdata_ready && (beat_cnt == LAST_BEAT)) begin
                    next_state = IDLE;
                end else begin
                    next_state = RBURST;
                end
            end
            WBURST: begin
                if (i_wdata_valid && (beat_cnt == LAST_BEAT)) begin
                    next_state = (LATENCY > 0) ? WWAIT : WDONE;
                end else begin
                    next_state = WBURST;
                end
            end
            WWAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    next_state = WDONE;
                end else begin
                    next_state = WWAIT;
                end
            end
            WDONE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register and registered handshake/status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            rdata_valid <= 1'b0;
            wdata_ready <= 1'b0;
            wr_done     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= next_state;
            req_ready   <= (next_state == IDLE);
            rdata_valid <= (next_state == RBURST);
            wdata_ready <= (next_state == WBURST);
            wr_done     <= (next_state == WDONE);
            busy        <= (next_state != IDLE);
        end
    end

    // Request capture, latency counter and beat pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt  <= 4'd0;
            beat_cnt <= {PTR_BITS{1'b0}};
            ptr      <= {PTR_BITS{1'b0}};
            slot     <= {SLOT_BITS{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        slot     <= slot_in;
                        ptr      <= i_req_write ? {PTR_BITS{1'b0}} : i_req_word;
                        beat_cnt <= {PTR_BITS{1'b0}};
                        lat_cnt  <= 4'd0;
                    end
                end
                RWAIT, WWAIT: lat_cnt <= lat_cnt + 4'd1;
                RBURST: begin
                    if (i_rdata_ready) begin
                        ptr      <= ptr + {{(PTR_BITS-1){1'b0}}, 1'b1};
                        beat_cnt <= beat_cnt + {{(PTR_BITS-1){1'b0}}, 1'b1};
                    end
                end
                WBURST: begin
                    if (i_wdata_valid) begin
                        ptr      <= ptr + {{(PTR_BITS-1){1'b0}}, 1'b1};
                        beat_cnt <= beat_cnt + {{(PTR_BITS-1){1'b0}}, 1'b1};
                    end
                end
                default: lat_cnt <= lat_cnt;
            endcase
        end
    end

    line_store_ram #(
        .MEM_WORDS  (MEM_WORDS),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (SLOT_BITS + PTR_BITS)
    ) u_store (
        .clk   (clk),
        .we    (ram_we),
        .addr  ({slot, ptr}),
        .wdata (i_wdata),
        .rdata (ram_q)
    );

    assign o_req_ready   = req_ready;
    assign o_rdata_valid = rdata_valid;
    assign o_wdata_ready = wdata_ready;
    assign o_wr_done     = wr_done;
    assign o_busy        = busy;
    assign o_rdata       = rdata_valid ? ram_q : {DATA_WIDTH{1'b0}};
    assign o_rdata_last  = rdata_valid && (beat_cnt == LAST_BEAT);

endmodule

// File: tb/tb_cache_line_mem_responder.sv
// Bench for the line responder: table of line requests with a read-beat scoreboard,
// plus reset-abort and zero-latency sequences on a second instance.
module tb_cache_line_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [25:0] req_addr = 26'd0;
    logic [3:0]  req_word = 4'd0;
    logic        wdata_valid = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        rdata_ready = 1'b0;

    logic        a_req_ready, a_wdata_ready, a_rdata_valid, a_rdata_last, a_wr_done, a_busy;
    logic        b_req_ready, b_wdata_ready, b_rdata_valid, b_rdata_last, b_wr_done, b_busy;
    logic [31:0] a_rdata, b_rdata;

    logic        sel = 1'b0;
    int          lat = 4;
    logic        req_ready, wdata_ready, rdata_valid, rdata_last, wr_done, busy;
    logic [31:0] rdata;

    assign req_ready   = sel ? b_req_ready   : a_req_ready;
    assign wdata_ready = sel ? b_wdata_ready : a_wdata_ready;
    assign rdata_valid = sel ? b_rdata_valid : a_rdata_valid;
    assign rdata_last  = sel ? b_rdata_last  : a_rdata_last;
    assign wr_done     = sel ? b_wr_done     : a_wr_done;
    assign busy        = sel ? b_busy        : a_busy;
    assign rdata       = sel ? b_rdata       : a_rdata;

    always #5 clk = ~clk;

    cache_line_mem_responder #(.LATENCY(4)) dut (
        .clk(clk), .rst(rst), .i_req_valid(req_valid), .o_req_ready(a_req_ready),
        .i_req_write(req_write), .i_req_addr(req_addr), .i_req_word(req_word),
        .i_wdata_valid(wdata_valid), .o_wdata_ready(a_wdata_ready), .i_wdata(wdata),
        .o_rdata_valid(a_rdata_valid), .i_rdata_ready(rdata_ready), .o_rdata(a_rdata),
        .o_rdata_last(a_rdata_last), .o_wr_done(a_wr_done), .o_busy(a_busy)
    );

    cache_line_mem_responder #(.LATENCY(0)) dut_lat0 (
        .clk(clk), .rst(rst), .i_req_valid(req_valid), .o_req_ready(b_req_ready),
        .i_req_write(req_write), .i_req_addr(req_addr), .i_req_word(req_word),
        .i_wdata_valid(wdata_valid), .o_wdata_ready(b_wdata_ready), .i_wdata(wdata),
        .o_rdata_valid(b_rdata_valid), .i_rdata_ready(rdata_ready), .o_rdata(b_rdata),
        .o_rdata_last(b_rdata_last), .o_wr_done(b_wr_done), .o_busy(b_busy)
    );

    typedef struct {
        logic        wr;
        logic [25:0] addr;
        logic [3:0]  word;
        logic [31:0] base;
        logic        stall;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] sb [$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [25:0] a, input logic [3:0] w);
        int t;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_word = w;
        t = 0;
        while (req_ready !== 1'b1 && t < 64) begin
            @(negedge clk); t++;
        end
        check("req_accept_in_time", 32'(t < 64), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic write_line(input logic [25:0] a, input logic [31:0] base);
        int t;
        int n;
        issue(1'b1, a, 4'd0);
        wdata_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            wdata = base + 32'(k);
            t = 0;
            while (wdata_ready !== 1'b1 && t < 64) begin
                @(negedge clk); t++;
            end
            check("wready_continuous", 32'(t), 32'd0);
            @(negedge clk);
        end
        wdata = 32'hDEADBEEF;
        check("wready_drop", 32'(wdata_ready), 32'd0);
        n = 1;
        while (wr_done !== 1'b1 && n < 64) begin
            @(negedge clk); wdata_valid = 1'b0; n++;
        end
        check("wr_done_delay", 32'(n), 32'(lat + 1));
        @(negedge clk);
        wdata_valid = 1'b0;
        check("wr_done_single_pulse", 32'(wr_done), 32'd0);
        check("req_ready_after_write", 32'(req_ready), 32'd1);
    endtask

    task automatic read_line(input logic [25:0] a, input logic [3:0] w,
                             input logic [31:0] base, input logic stall);
        int n;
        int acc;
        int cyc;
        logic        stalled;
        logic [31:0] held;
        logic        held_last;
        logic [31:0] exp;
        issue(1'b0, a, w);
        for (int k = 0; k < 16; k++) sb.push_back(base + 32'((32'(w) + 32'(k)) % 32'd16));
        n = 1;
        while (rdata_valid !== 1'b1 && n < 64) begin
            @(negedge clk); n++;
        end
        check("first_valid_cycle", 32'(n), 32'(lat + 1));
        if (stall) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 26'h3FF;
        end
        acc = 0; cyc = 0; stalled = 1'b0; held = 32'd0; held_last = 1'b0;
        while (acc < 16 && cyc < 200) begin
            if (stalled) begin
                check("stall_data_hold", rdata, held);
                check("stall_last_hold", 32'(rdata_last), 32'(held_last));
            end
            rdata_ready = stall ? (cyc % 2 == 0) : 1'b1;
            if (acc == 15) req_valid = 1'b0;
            if (stall) check("no_req_mid_burst", 32'(req_ready), 32'd0);
            if (rdata_ready && rdata_valid) begin
                exp = sb.pop_front();
                check("rdata", rdata, exp);
                check("rdata_last", 32'(rdata_last), 32'(acc == 15));
                acc++;
            end
            stalled = !rdata_ready && rdata_valid;
            held = rdata; held_last = rdata_last;
            @(negedge clk); cyc++;
        end
        rdata_ready = 1'b0; req_valid = 1'b0;
        check("burst_beats", 32'(acc), 32'd16);
        check("valid_drop", 32'(rdata_valid), 32'd0);
        check("req_ready_after_read", 32'(req_ready), 32'd1);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 26'h000123, 4'd0,  32'hA0000000, 1'b0};
        vecs[1] = '{1'b0, 26'h000123, 4'd0,  32'hA0000000, 1'b0};
        vecs[2] = '{1'b0, 26'h000123, 4'd13, 32'hA0000000, 1'b0};
        vecs[3] = '{1'b0, 26'h000123, 4'd0,  32'hA0000000, 1'b1};
        vecs[4] = '{1'b0, 26'h000023, 4'd0,  32'hA0000000, 1'b0};
        vecs[5] = '{1'b1, 26'h000045, 4'd0,  32'hB0000000, 1'b0};
        vecs[6] = '{1'b0, 26'h000345, 4'd7,  32'hB0000000, 1'b0};

        #12;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        check("rst_wdata_ready", 32'(wdata_ready), 32'd0);
        check("rst_wr_done", 32'(wr_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("req_ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("req_ready_after_release", 32'(req_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].wr) write_line(vecs[i].addr, vecs[i].base);
            else            read_line(vecs[i].addr, vecs[i].word, vecs[i].base, vecs[i].stall);
        end

        // Abort a read after 5 beats with an asynchronous reset.
        issue(1'b0, 26'h000123, 4'd0);
        begin
            int t;
            int acc;
            t = 0; acc = 0;
            rdata_ready = 1'b1;
            while (acc < 5 && t < 64) begin
                if (rdata_valid) acc++;
                @(negedge clk); t++;
            end
            check("abort_beats_seen", 32'(acc), 32'd5);
        end
        #2 rst = 1'b1;
        #1;
        check("abort_rdata_valid", 32'(rdata_valid), 32'd0);
        check("abort_rdata", rdata, 32'd0);
        check("abort_rdata_last", 32'(rdata_last), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd0);
        rdata_ready = 1'b0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready_low_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("abort_ready_after_edge", 32'(req_ready), 32'd1);
        read_line(26'h000123, 4'd0, 32'hA0000000, 1'b0);

        // Zero-latency instance.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sel = 1'b1; lat = 0;
        @(negedge clk);
        check("lat0_ready", 32'(req_ready), 32'd1);
        write_line(26'h000007, 32'hC0000000);
        read_line(26'h000007, 4'd3, 32'hC0000000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
